decoder_3x8_seq: RTL and testbench

//  Sequenced 3-to-8 decoder: the receive-side counterpart of the 8x3 priority encoder.
//  - Accepts 3-bit codes over a valid/ready handshake and queues them in a small FIFO.
//  - Replays each code as a one-hot 8-bit word on dout, holding it HOLD_CYCLES cycles.
//  - Drives per-line enables/strobes from encoded indices without dropping codes

---
 rtl/decoder_3x8_seq.sv | 137 +++++++++++++
 tb/tb_decoder_3x8_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder: queues 3-bit codes from a valid/ready input and
// replays each as a one-hot word held for HOLD_CYCLES cycles, back-to-back.
module decoder_3x8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic [2:0] din,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int HW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CNTW-1:0] FIFO_FULL   = CNTW'(DEPTH);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_cnt_next;
    logic [7:0]      r_dout;
    logic [7:0]      w_dout_next;
    logic            r_dout_valid;
    logic            w_dout_valid_next;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_empty;
    logic [2:0]      w_head;
    logic [7:0]      w_decoded;

    assign w_fifo_empty = (r_count == '0);
    assign din_ready    = rst_n & (r_count != FIFO_FULL);
    assign w_push       = din_valid & din_ready;
    assign w_head       = r_mem[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign w_decoded[gi] = (w_head == 3'(gi));
        end
    endgenerate

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_hold_cnt   <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_dout_valid_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_hold_cnt_next   = r_hold_cnt;
        w_dout_next       = r_dout;
        w_dout_valid_next = r_dout_valid;
        w_pop             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop             = 1'b1;
                    w_dout_next       = w_decoded;
                    w_dout_valid_next = 1'b1;
                    w_hold_cnt_next   = HOLD_RELOAD;
                    w_state_next      = S_HOLD;
                end else begin
                    w_dout_next       = 8'h00;
                    w_dout_valid_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt != '0) begin
                    w_hold_cnt_next = r_hold_cnt - HW'(1);
                end else if (!w_fifo_empty) begin
                    // Chain straight into the next word so bursts leave no gap.
                    w_pop             = 1'b1;
                    w_dout_next       = w_decoded;
                    w_dout_valid_next = 1'b1;
                    w_hold_cnt_next   = HOLD_RELOAD;
                end else begin
                    w_dout_next       = 8'h00;
                    w_dout_valid_next = 1'b0;
                    w_state_next      = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = !w_fifo_empty | (r_state == S_HOLD);

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: two instances (hold 4 and hold 1) checked every
// cycle against a queue-of-words model of accepted codes.
module tb_decoder_3x8_seq;
    localparam int DEPTH = 4;
    localparam int QN    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       dv [2];
    logic [2:0] di [2];
    logic       dr [2];
    logic [7:0] dout_w [2];
    logic       ov [2];
    logic       busy_w [2];

    decoder_3x8_seq #(.HOLD_CYCLES(4), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din_valid(dv[0]), .din(di[0]),
        .din_ready(dr[0]), .dout(dout_w[0]), .dout_valid(ov[0]), .busy(busy_w[0])
    );
    decoder_3x8_seq #(.HOLD_CYCLES(1), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_valid(dv[1]), .din(di[1]),
        .din_ready(dr[1]), .dout(dout_w[1]), .dout_valid(ov[1]), .busy(busy_w[1])
    );

    // Model: accepted-but-not-started words, tagged with the edge they were taken.
    int         hold_of [2] = '{4, 1};
    logic [7:0] exp_word [2][QN];
    int         exp_edge [2][QN];
    int         head [2];
    int         tail [2];
    int         rem [2];
    logic [7:0] cur [2];
    int         acc_cnt [2];
    int         edge_n = 0;
    bit         rst_seen = 1'b0;
    int         n_pass = 0;
    int         n_checks = 0;
    int         n_timeout = 0;

    task automatic chk(string name, int d, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d edge %0d: got %02h expected %02h", name, d, edge_n, act, exp);
    endtask

    always @(posedge clk) begin
        edge_n++;
        rst_seen = !rst_n;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && dv[d] && dr[d]) begin
                exp_word[d][tail[d] % QN] = 8'h01 << di[d];
                exp_edge[d][tail[d] % QN] = edge_n;
                tail[d]++;
                acc_cnt[d]++;
            end
        end
    end

    always @(negedge clk) begin
        logic       ev;
        logic [7:0] ed;
        int         sz;
        for (int d = 0; d < 2; d++) begin
            if (rst_seen) begin
                head[d] = tail[d];
                rem[d]  = 0;
            end
            sz = tail[d] - head[d];
            ev = (rem[d] > 0) || (sz > 0 && exp_edge[d][head[d] % QN] < edge_n);
            if (ev && rem[d] == 0) begin
                cur[d] = exp_word[d][head[d] % QN];
                head[d]++;
                rem[d] = hold_of[d];
                $display("dut%0d edge %0d: word %02h", d, edge_n, cur[d]);
            end
            ed = ev ? cur[d] : 8'h00;
            if (ev) rem[d]--;
            sz = tail[d] - head[d];
            chk("dout_valid", d, {7'd0, ov[d]}, {7'd0, ev});
            chk("dout", d, dout_w[d], ed);
            chk("din_ready", d, {7'd0, dr[d]}, {7'd0, (rst_n && sz < DEPTH)});
            chk("busy", d, {7'd0, busy_w[d]}, {7'd0, (sz != 0 || ev)});
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int d, int code);
        int start;
        start = acc_cnt[d];
        dv[d] = 1'b1;
        di[d] = 3'(code);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt[d] != start) return;
        end
        n_timeout++;
        $display("FAIL send_timeout dut%0d: code %0d not accepted, required within 300 cycles", d, code);
        dv[d] = 1'b0;
    endtask

    task automatic drain(int d);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (head[d] == tail[d] && rem[d] == 0 && busy_w[d] === 1'b0) return;
        end
        n_timeout++;
        $display("FAIL drain_timeout dut%0d: busy=%b pending=%0d, required idle within 500 cycles",
                 d, busy_w[d], tail[d] - head[d]);
    endtask

    initial begin
        // Reset held with valid asserted: nothing may be queued.
        rst_n = 1'b0;
        dv[0] = 1'b1; dv[1] = 1'b1;
        di[0] = 3'd3; di[1] = 3'd6;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dv[0] = 1'b0; dv[1] = 1'b0;
        idle(4);

        send(0, 5);
        dv[0] = 1'b0;
        drain(0);

        for (int c = 0; c < 8; c++) send(0, c);
        dv[0] = 1'b0;
        drain(0);

        send(1, 7); send(1, 0); send(1, 7);
        dv[1] = 1'b0;
        drain(1);

        // Random traffic on both instances; enough codes for several pointer laps.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(3) == 0) begin
                        dv[0] = 1'b0;
                        idle(int'($urandom_range(1, 3)));
                    end
                    send(0, int'($urandom_range(7)));
                end
                dv[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(3) == 0) begin
                        dv[1] = 1'b0;
                        idle(int'($urandom_range(1, 3)));
                    end
                    send(1, int'($urandom_range(7)));
                end
                dv[1] = 1'b0;
            end
        join
        drain(0);
        drain(1);

        // Reset mid-hold with three codes queued, then a single fresh code.
        send(0, 1); send(0, 3); send(0, 6); send(0, 4);
        dv[0] = 1'b0;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(0, 2);
        dv[0] = 1'b0;
        drain(0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
        $finish;
    end
endmodule
